// File: rtl/redmule_pkg.sv
// Shared types for the TCDM responder: the response record and address-field width helper.
// Pure declarations; no logic, no latency, no flow control.
package redmule_pkg;

    localparam int unsigned RSP_DW = 32;

    typedef struct packed {
        logic [RSP_DW-1:0] r_data;
        logic              r_valid;
        logic              r_opc;
    } tcdm_rsp_t;

    // Width of an index field selecting one of n items (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/redmule_tcdm_bank.sv
// One word bank: round-robin arbiter over the ports, row storage and a read register.
// Grant is combinational; read data is registered one cycle later; losers simply hold their request.
module redmule_tcdm_bank
    import redmule_pkg::*;
#(
    parameter int unsigned MP         = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned BANK_WORDS = 1024,
    localparam int unsigned RB        = idx_w(BANK_WORDS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [MP-1:0]          req_i,
    input  logic [MP-1:0][RB-1:0]  row_i,
    input  logic [MP-1:0]          wen_i,
    input  logic [MP-1:0][DW/8-1:0] be_i,
    input  logic [MP-1:0][DW-1:0]  data_i,
    output logic [MP-1:0]          gnt_o,
    output logic [DW-1:0]          rdata_o
);

    localparam int unsigned PW = idx_w(MP);

    logic [PW-1:0] ptr_q, ptr_d, win, cand;
    logic          found;
    logic [RB-1:0] win_row;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] mem [BANK_WORDS];

    // Scan ports starting at the pointer; the first requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < MP; k++) begin
            cand = PW'((int'(ptr_q) + k) % MP);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ptr_d = ptr_q;
        if (found) ptr_d = (win == PW'(MP - 1)) ? '0 : win + PW'(1);
        gnt_o = '0;
        if (found) gnt_o[win] = 1'b1;
        win_row = row_i[win];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (found) rdata_q <= mem[win_row];
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (found && !wen_i[win]) begin
            for (int by = 0; by < DW/8; by++) begin
                if (be_i[win][by]) mem[win_row][by*8 +: 8] <= data_i[win][by*8 +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Multi-port word-interleaved TCDM responder: same-cycle grant, response exactly one cycle after grant.
// Ungranted ports hold; optional random stalling via REDMULE_TCDM_STALL_EN (16-bit LFSR grant mask).
module redmule_tcdm_responder
    import redmule_pkg::*;
#(
    parameter int unsigned   MP         = 4,
    parameter int unsigned   DW         = 32,
    parameter int unsigned   AW         = 32,
    parameter int unsigned   NB         = 8,
    parameter int unsigned   BANK_WORDS = 1024,
    parameter logic [AW-1:0] BASE_ADDR  = AW'(32'h1000_0000)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [MP-1:0]           tcdm_req_i,
    output logic [MP-1:0]           tcdm_gnt_o,
    input  logic [MP-1:0][AW-1:0]   tcdm_add_i,
    input  logic [MP-1:0]           tcdm_wen_i,
    input  logic [MP-1:0][DW/8-1:0] tcdm_be_i,
    input  logic [MP-1:0][DW-1:0]   tcdm_data_i,
    output logic [MP-1:0][DW-1:0]   tcdm_r_data_o,
    output logic [MP-1:0]           tcdm_r_valid_o,
    output logic [MP-1:0]           tcdm_r_opc_o
);

    localparam int unsigned   OFFB      = $clog2(DW/8);
    localparam int unsigned   BB        = idx_w(NB);
    localparam int unsigned   RB        = idx_w(BANK_WORDS);
    localparam logic [AW:0]   MEM_BYTES = (AW+1)'(NB * BANK_WORDS * (DW/8));

    logic [MP-1:0][AW-1:0] offset;
    logic [MP-1:0]         in_range, allow, port_req;
    logic [MP-1:0][BB-1:0] bank_idx, bsel_q;
    logic [MP-1:0][RB-1:0] row;
    logic [NB-1:0][MP-1:0] bank_req, bank_gnt;
    logic [NB-1:0][DW-1:0] bank_rdata;
    logic [MP-1:0]         vld_d, vld_q, opc_d, opc_q, rd_d, rd_q;
    tcdm_rsp_t [MP-1:0]    rsp;

`ifdef REDMULE_TCDM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= 16'hACE1;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        allow = '0;
        for (int i = 0; i < MP; i++) allow[i] = lfsr_q[i % 16];
    end
`else
    assign allow = '1;
`endif

    // Masked ports never reach a bank, so they leave its pointer untouched.
    always_comb begin
        bank_req = '0;
        for (int i = 0; i < MP; i++) begin
            offset[i]   = tcdm_add_i[i] - BASE_ADDR;
            in_range[i] = {1'b0, offset[i]} < MEM_BYTES;
            bank_idx[i] = offset[i][OFFB +: BB];
            row[i]      = offset[i][OFFB + BB +: RB];
            port_req[i] = tcdm_req_i[i] & allow[i];
            for (int b = 0; b < NB; b++) begin
                bank_req[b][i] = port_req[i] & in_range[i] & (bank_idx[i] == BB'(b));
            end
            tcdm_gnt_o[i] = port_req[i] & (in_range[i] ? bank_gnt[bank_idx[i]][i] : 1'b1);
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        redmule_tcdm_bank #(
            .MP         (MP),
            .DW         (DW),
            .BANK_WORDS (BANK_WORDS)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .req_i   (bank_req[b]),
            .row_i   (row),
            .wen_i   (tcdm_wen_i),
            .be_i    (tcdm_be_i),
            .data_i  (tcdm_data_i),
            .gnt_o   (bank_gnt[b]),
            .rdata_o (bank_rdata[b])
        );
    end

    assign vld_d = tcdm_gnt_o;
    assign opc_d = tcdm_gnt_o & ~in_range;
    assign rd_d  = tcdm_gnt_o & in_range & tcdm_wen_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            opc_q  <= '0;
            rd_q   <= '0;
            bsel_q <= '0;
        end else begin
            vld_q  <= vld_d;
            opc_q  <= opc_d;
            rd_q   <= rd_d;
            bsel_q <= bank_idx;
        end
    end

    // Only an in-range read forwards the serving bank's register; everything else returns zero.
    always_comb begin
        for (int i = 0; i < MP; i++) begin
            rsp[i].r_valid    = vld_q[i];
            rsp[i].r_opc      = opc_q[i];
            rsp[i].r_data     = rd_q[i] ? RSP_DW'(bank_rdata[bsel_q[i]]) : '0;
            tcdm_r_valid_o[i] = rsp[i].r_valid;
            tcdm_r_opc_o[i]   = rsp[i].r_opc;
            tcdm_r_data_o[i]  = rsp[i].r_data[DW-1:0];
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Scoreboard bench: a word-level memory/round-robin reference predicts grants and responses.
module tb_redmule_tcdm_responder;

    localparam int MP = 4, DW = 32, AW = 32, NB = 8, BW = 1024;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int MEMB = NB * BW * 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [MP-1:0]           req = '0, gnt, wen = '0, r_valid, r_opc;
    logic [MP-1:0][AW-1:0]   add = '0;
    logic [MP-1:0][DW/8-1:0] be = '0;
    logic [MP-1:0][DW-1:0]   wdata = '0, r_data;

    always #5 clk = ~clk;

    redmule_tcdm_responder #(.MP(MP), .DW(DW), .AW(AW), .NB(NB), .BANK_WORDS(BW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add),
        .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(r_data),
        .tcdm_r_valid_o(r_valid), .tcdm_r_opc_o(r_opc)
    );

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
        logic        opc;
    } exp_t;

    exp_t          sbq[$];
    logic [31:0]   mem_m [NB*BW];
    int            ptr_m [NB];
    logic [MP-1:0] exp_gnt, gnt_seen;
    int            cyc = 0;
    int            total = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle, each port must show exactly the responses scheduled for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic [MP-1:0]       ev, eo;
                logic [MP-1:0][31:0] ed;
                exp_t                e;
                ev = '0; eo = '0; ed = '0;
                while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                    e = sbq.pop_front();
                    ev[e.port] = 1'b1;
                    eo[e.port] = e.opc;
                    ed[e.port] = e.data;
                end
                for (int p = 0; p < MP; p++) begin
                    total++;
                    if (r_valid[p] !== ev[p] || r_opc[p] !== eo[p] || r_data[p] !== ed[p]) begin
                        bad++;
                        $display("FAIL rsp port%0d cyc=%0d: got v=%b opc=%b data=%h, want v=%b opc=%b data=%h",
                                 p, cyc, r_valid[p], r_opc[p], r_data[p], ev[p], eo[p], ed[p]);
                    end
                end
            end
        end
    end

    task automatic clear_in();
        req = '0; wen = '0; be = '0; wdata = '0; add = '0;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        req[p] = 1'b1; add[p] = a; wen[p] = w; be[p] = b; wdata[p] = d;
    endtask

    // Inputs are already applied; predict this cycle, check the grant, schedule responses, advance.
    task automatic step();
        logic [31:0] off;
        bit          inr [MP];
        int          wd [MP];
        @(negedge clk);
        exp_gnt = '0;
        for (int i = 0; i < MP; i++) begin
            off    = add[i] - BASE;
            inr[i] = (off < 32'(MEMB));
            wd[i]  = int'(off >> 2);
            if (req[i] && !inr[i]) exp_gnt[i] = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < MP; k++) begin
                int p;
                p = (ptr_m[b] + k) % MP;
                if (req[p] && inr[p] && (wd[p] % NB) == b) begin
                    exp_gnt[p] = 1'b1;
                    ptr_m[b]   = (p + 1) % MP;
                    break;
                end
            end
        end
        gnt_seen = gnt;
        total++;
        if (gnt !== exp_gnt) begin
            bad++;
            $display("FAIL gnt cyc=%0d: got %b want %b", cyc, gnt, exp_gnt);
        end
        for (int i = 0; i < MP; i++) begin
            if (exp_gnt[i]) begin
                exp_t e;
                e.cyc  = cyc + 1;
                e.port = i;
                e.opc  = !inr[i];
                e.data = (inr[i] && wen[i]) ? mem_m[wd[i]] : 32'h0;
                sbq.push_back(e);
            end
        end
        for (int i = 0; i < MP; i++) begin
            if (exp_gnt[i] && inr[i] && !wen[i]) begin
                for (int by = 0; by < 4; by++) begin
                    if (be[i][by]) mem_m[wd[i]][by*8 +: 8] = wdata[i][by*8 +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pool_word(input int k);
        return (k < 32) ? k : NB * BW - 40 + k;
    endfunction

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 8)  return BASE - 32'(4 * $urandom_range(1, 4));
        if (r < 14) return BASE + 32'(MEMB) + 32'(4 * $urandom_range(0, 3));
        return BASE + 32'(4 * pool_word($urandom_range(0, 39)));
    endfunction

    initial begin
        logic [MP-1:0] held;
        foreach (ptr_m[b]) ptr_m[b] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        step();  // idle after reset: no grants, no responses

        // Fill the address pool so every later read has a defined value.
        for (int k = 0; k < 40; k += 4) begin
            clear_in();
            for (int p = 0; p < MP; p++) set_port(p, BASE + 32'(4 * pool_word(k + p)), 1'b0, 4'hF, $urandom());
            step();
        end

        // Write then read back on port 0.
        clear_in(); set_port(0, BASE, 1'b0, 4'hF, 32'hDEADBEEF); step();
        clear_in(); set_port(0, BASE, 1'b1, 4'h0, 32'h0);        step();

        // Four ports to four different banks in one cycle.
        clear_in();
        for (int p = 0; p < MP; p++) set_port(p, BASE + 32'(4 * p), 1'b1, 4'h0, 32'h0);
        step();

        // Byte-enable merge: expected read 11BB33DD.
        clear_in(); set_port(1, BASE + 32'h10, 1'b0, 4'hF, 32'h11223344); step();
        clear_in(); set_port(1, BASE + 32'h10, 1'b0, 4'b0101, 32'hAABBCCDD); step();
        clear_in(); set_port(1, BASE + 32'h10, 1'b1, 4'h0, 32'h0); step();

        // Out-of-range on both sides, including a write that aliases word 0 if decoded wrongly.
        clear_in();
        set_port(1, BASE - 32'h4, 1'b1, 4'h0, 32'h0);
        set_port(2, BASE + 32'(MEMB), 1'b1, 4'h0, 32'h0);
        set_port(3, BASE + 32'(MEMB), 1'b0, 4'hF, 32'h0BAD0BAD);
        step();
        clear_in(); set_port(0, BASE, 1'b1, 4'h0, 32'h0); step();

        // Reset right after a grant: pending response dropped, pointers cleared, memory kept.
        clear_in(); set_port(0, BASE + 32'h40, 1'b1, 4'h0, 32'h0); step();
        rst_n = 1'b0;
        clear_in();
        sbq.delete();
        foreach (ptr_m[b]) ptr_m[b] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All ports hammer bank 0: grants must rotate 0,1,2,3 from a cleared pointer.
        clear_in();
        for (int p = 0; p < MP; p++) set_port(p, BASE + 32'(32 * p), 1'b1, 4'h0, 32'h0);
        for (int k = 0; k < MP; k++) begin
            step();
            total++;
            if (gnt_seen !== MP'(1 << k)) begin
                bad++;
                $display("FAIL rr rotation step%0d: got %b want %b", k, gnt_seen, MP'(1 << k));
            end
        end
        clear_in(); set_port(2, BASE, 1'b1, 4'h0, 32'h0); step();

        // Random traffic; a port that loses keeps its request unchanged.
        clear_in();
        held = '0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < MP; p++) begin
                if (!held[p]) begin
                    if ($urandom_range(0, 9) < 7)
                        set_port(p, pick_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
                    else
                        req[p] = 1'b0;
                end
            end
            step();
            held = req & ~exp_gnt;
        end

        clear_in();
        repeat (3) step();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL leftover responses: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
